uart_cmd_tx: RTL
================

Name: uart_cmd_tx

Overview:
- Transmit end of the 16-bit command link: takes a 16-bit command word and serializes it onto a single UART line as two 8N1 bytes, high byte first then low byte.
- It is the sender that pairs with the follower's command receiver, which assembles two received bytes into one command.
- Used in the remote/test-harness side of the design; it contains its own baud generator, bit shifter and byte-sequencing state machine.

Parameters:
- BAUD_DIV, 2604: clk cycles per UART bit time (50 MHz / 19200 baud). Legal range 4..4095, 12-bit counter.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  reset.
- cmd  input  16  command word; sampled only when a send is accepted.
- snd_cmd  input  1  single-cycle pulse that requests transmission of cmd.
- TX  output  1  serial line; idles high.
- tx_busy  output  1  high while a command (either byte) is in flight.
- cmd_snt  output  1  high from completion of a command until the next accepted snd_cmd.

Behaviour:
- Reset: rst_n, asynchronous, active-low; clock clk. Reset values are TX=1, tx_busy=0, cmd_snt=0, state=IDLE, and baud/bit counters cleared.
- Reset asserted mid-frame aborts the frame immediately: TX returns to 1 asynchronously and no partial byte is resumed after release.
- Frame format per byte: start bit (0), data bits [0]..[7] LSB first, stop bit (1). Each bit is held exactly BAUD_DIV clocks. One command = 20 bit times = 20*BAUD_DIV clocks.
- Acceptance: snd_cmd is accepted only in IDLE. On the accepting edge:
  - cmd is captured into a 16-bit holding register.
  - cmd_snt clears to 0.
  - tx_busy goes to 1.
  - The high byte cmd[15:8] is loaded into the 10-bit shifter {1, byte, 0}.
  - TX drives the start bit from the next cycle (latency 1 clk).
- snd_cmd while tx_busy=1 is ignored. No queuing, and the holding register is not disturbed.
- Changes on cmd after acceptance have no effect on the frame.
- Shifter: TX = shifter[0]. When the baud counter reaches BAUD_DIV-1, the counter resets to 0, the shifter shifts right with a 1 filled in, and the bit counter increments. A byte is done after 10 shifts.
- State machine:
  - IDLE: TX=1. Accepted snd_cmd -> SEND_HI.
  - SEND_HI: 10 bit times of the high byte. On the 10th shift, load the low byte cmd[7:0] with no idle gap, so the low start bit immediately follows the high stop bit -> SEND_LO.
  - SEND_LO: 10 bit times. On the 10th shift -> IDLE, tx_busy=0 and cmd_snt=1 on the same edge.
- cmd_snt stays high indefinitely until the next accepted snd_cmd.
- Back-to-back: snd_cmd on the first IDLE cycle after completion is accepted. The minimum inter-command line idle is 1 clk.
- tx_busy is asserted for exactly 20*BAUD_DIV clocks per command.
- Counter arithmetic is unsigned. The baud counter never exceeds BAUD_DIV-1 and the bit counter never exceeds 10; both wrap to 0.

Test Plan:
- Basic frame: BAUD_DIV=16, cmd=16'hA5C3, single snd_cmd. Sample TX mid-bit and require the line sequence 0,1,0,1,0,0,1,0,1,1 (0xA5) then 0,1,1,0,0,0,0,1,1,1 (0xC3). tx_busy must be high for 320 clks, then cmd_snt=1 and TX=1.
- Loopback: feed TX into the existing UART command receiver. Send 16'h0003, 16'hFFFF and 16'h8001; each must be reported by the receiver with cmd_rdy and an exact cmd match.
- Busy ignore: 50 clks into sending 16'h1234, pulse snd_cmd with cmd=16'hBEEF. Only 0x12 then 0x34 may appear, tx_busy must fall at exactly 320 clks, and no second frame may follow.
- cmd hold: change cmd to 16'h0000 one clk after acceptance of 16'h5A5A. The line must still carry 0x5A, 0x5A.
- Back-to-back: assert snd_cmd on the first cycle tx_busy=0. cmd_snt must pulse high for 1 clk and TX must idle high for 1 clk before the new start bit.
- Reset mid-frame: assert rst_n=0 during bit 4 of the low byte. TX=1, tx_busy=0 and cmd_snt=0 immediately; after release the line stays idle until a new snd_cmd.

Source files
------------

// File: rtl/uart_cmd_tx.sv
// UART command transmitter: sends a 16-bit command as two 8N1 bytes,
// high byte first, with an internal baud generator and byte sequencer.
module uart_cmd_tx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        TX,
  output logic        tx_busy,
  output logic        cmd_snt
);

  typedef enum logic [1:0] {
    IDLE,
    SEND_HI,
    SEND_LO
  } state_t;

  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);

  state_t      state, state_nxt;
  logic [11:0] baud_cnt, baud_cnt_nxt;
  logic [3:0]  bit_cnt, bit_cnt_nxt;
  logic [9:0]  shifter, shifter_nxt;
  logic [15:0] cmd_hold, cmd_hold_nxt;
  logic        tx_busy_nxt;
  logic        cmd_snt_nxt;
  logic        baud_tick;
  logic        last_bit;
  logic [7:0]  unused_hi_byte;

  // The high byte goes straight from cmd into the shifter on acceptance,
  // so only the low half of the holding register feeds the datapath.
  assign unused_hi_byte = cmd_hold[15:8];

  assign baud_tick = (baud_cnt == BAUD_LAST);
  assign last_bit  = (bit_cnt == 4'd9);
  assign TX        = shifter[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shifter  <= '1;
      cmd_hold <= '0;
      tx_busy  <= 1'b0;
      cmd_snt  <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shifter  <= shifter_nxt;
      cmd_hold <= cmd_hold_nxt;
      tx_busy  <= tx_busy_nxt;
      cmd_snt  <= cmd_snt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = baud_cnt;
    bit_cnt_nxt  = bit_cnt;
    shifter_nxt  = shifter;
    cmd_hold_nxt = cmd_hold;
    tx_busy_nxt  = tx_busy;
    cmd_snt_nxt  = cmd_snt;

    case (state)
      IDLE: begin
        baud_cnt_nxt = '0;
        bit_cnt_nxt  = '0;
        shifter_nxt  = '1;
        if (snd_cmd) begin
          cmd_hold_nxt = cmd;
          shifter_nxt  = {1'b1, cmd[15:8], 1'b0};
          tx_busy_nxt  = 1'b1;
          cmd_snt_nxt  = 1'b0;
          state_nxt    = SEND_HI;
        end
      end

      SEND_HI, SEND_LO: begin
        if (!baud_tick) begin
          baud_cnt_nxt = baud_cnt + 12'd1;
        end else begin
          baud_cnt_nxt = '0;
          if (!last_bit) begin
            shifter_nxt = {1'b1, shifter[9:1]};
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else begin
            bit_cnt_nxt = '0;
            // Low start bit follows the high stop bit with no idle gap.
            if (state == SEND_HI) begin
              shifter_nxt = {1'b1, cmd_hold[7:0], 1'b0};
              state_nxt   = SEND_LO;
            end else begin
              shifter_nxt = '1;
              tx_busy_nxt = 1'b0;
              cmd_snt_nxt = 1'b1;
              state_nxt   = IDLE;
            end
          end
        end
      end

      default: begin
        state_nxt    = IDLE;
        baud_cnt_nxt = '0;
        bit_cnt_nxt  = '0;
        shifter_nxt  = '1;
        tx_busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule
